video_pll_reset_sequencer: RTL and testbench
============================================

VIDEO_PLL_RESET_SEQUENCER -- requirements
Module: video_pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RESET_STRETCH, default 16: number of cycles pll_rst is held high per attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive synchronized-locked cycles required before domain release.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536: maximum number of cycles per attempt, counted in WAIT_LOCK plus STABLE.
REQ-004 SHALL have parameter MAX_RETRIES, default 4: number of timed-out attempts that triggers FAULT.
REQ-005 SHALL have parameter RELEASE_GAP, default 8: number of cycles between successive domain releases.
REQ-006 SHALL have parameter NUM_DOMAINS, default 3: number of downstream reset domains, one per PLL output clock.
REQ-007 SHALL have port refclk, input, width 1: the single clock, 50 MHz.
REQ-008 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-009 SHALL have port locked, input, width 1: the PLL lock indication, asynchronous to refclk.
REQ-010 SHALL have port pll_rst, output, width 1: reset to the PLL.
REQ-011 SHALL have port domain_rst, output, width NUM_DOMAINS: per-domain reset, active-high.
REQ-012 SHALL have port ready, output, width 1: all domains released and lock held.
REQ-013 SHALL have port error, output, width 1: retries exhausted.
REQ-014 SHALL have port lock_lost_count, output, width 8: saturating count of lock-loss events.

Function
REQ-015 SHALL pass locked through a 2-flop synchronizer; all further references to locked mean locked_s, the synchronizer output.
REQ-016 SHALL implement the states PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN and FAULT.
REQ-017 PLL_RST SHALL drive pll_rst=1 and all domain_rst=1 for exactly RESET_STRETCH cycles, then go to WAIT_LOCK, clearing the timeout counter.
REQ-018 WAIT_LOCK SHALL go to STABLE when locked_s=1, with the stable counter set to 1.
REQ-019 STABLE SHALL increment the stable counter each cycle locked_s=1, go to RELEASE when the counter reaches LOCK_STABLE_CYCLES, and return to WAIT_LOCK on locked_s=0 without clearing the timeout counter.
REQ-020 When the timeout counter reaches TIMEOUT_CYCLES in WAIT_LOCK or STABLE, the block SHALL increment the retry count and enter FAULT if retries equal MAX_RETRIES, otherwise PLL_RST.
REQ-021 On RELEASE entry, domain_rst[0] SHALL go to 0 in the first RELEASE cycle, and domain_rst[i] SHALL go to 0 RELEASE_GAP cycles after domain_rst[i-1].
REQ-022 The state SHALL become RUN 1 cycle after domain_rst[NUM_DOMAINS-1] goes to 0, and ready SHALL be 1 only in RUN.
REQ-023 Entering RUN SHALL clear the retry count.
REQ-024 On locked_s=0 in RELEASE or RUN, the next cycle SHALL have all domain_rst=1, ready=0 and the state PLL_RST, and lock_lost_count SHALL increment, saturating at 255.
REQ-025 FAULT SHALL hold pll_rst=1, domain_rst all 1, ready=0 and error=1; FAULT SHALL be left only by rst.
REQ-026 pll_rst SHALL be 0 in every state except PLL_RST and FAULT.
REQ-027 All counters SHALL be sized with $clog2 of their limits plus 1 and SHALL NOT wrap.

Reset
REQ-028 While rst=1 at a refclk edge, the block SHALL enter PLL_RST with pll_rst=1, domain_rst all 1, ready=0, error=0, lock_lost_count=0, all counters 0 and synchronizer flops 0.
REQ-029 rst asserted in any state, including mid-RELEASE, SHALL abort immediately with no partial domain release retained.

Configuration
REQ-030 With macro VIDEO_PLL_SEQ_LOSS_CNT_EN defined, the block SHALL implement the lock_lost_count behaviour of REQ-024.
REQ-031 Without VIDEO_PLL_SEQ_LOSS_CNT_EN, the block SHALL keep the lock_lost_count port but tie it to 0 and contain no counter logic; all other behaviour SHALL be identical.

Structure
REQ-032 Package video_pll_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-033 The synchronizer SHALL be the sub-module video_pll_lock_sync, with ports refclk, rst, d and q.

Verification
REQ-034 RESET_STRETCH=4, LOCK_STABLE_CYCLES=8, RELEASE_GAP=2, NUM_DOMAINS=3; locked high from cycle 0 -> pll_rst falls after 4 cycles; domain_rst goes 110, then 100, then 000 at 2-cycle spacing; ready=1 one cycle after the last release.
REQ-035 locked pulses high for 5 cycles, then low, then high steadily -> the stable count restarts; release begins only after 8 consecutive high synchronized cycles.
REQ-036 locked never high, TIMEOUT_CYCLES=20, MAX_RETRIES=2 -> 2 pll_rst pulses, then error=1 with pll_rst held at 1.
REQ-037 In RUN, locked drops for 1 cycle -> domain_rst=111 and ready=0; lock_lost_count=1; the full re-sequence completes; repeated 300 times -> lock_lost_count saturates at 255.
REQ-038 rst is asserted during RELEASE after domain_rst=110 -> domain_rst=111 on the next edge and the state is PLL_RST; with the macro undefined, lock_lost_count stays 0 in the REQ-037 scenario.

Source files
------------

// File: rtl/video_pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// video_pll_seq_pkg
// Shared definitions for the video PLL reset sequencer:
//   - seq_state_t      : sequencer state encoding
//   - DEF_*            : default values for the sequencer parameters
//   - LOSS_COUNT_MAX   : saturation value of the lock-loss counter
// Optional feature macro used by the sequencer: VIDEO_PLL_SEQ_LOSS_CNT_EN
// ---------------------------------------------------------------------------
package video_pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } seq_state_t;

  localparam int DEF_RESET_STRETCH      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_TIMEOUT_CYCLES     = 65536;
  localparam int DEF_MAX_RETRIES        = 4;
  localparam int DEF_RELEASE_GAP        = 8;
  localparam int DEF_NUM_DOMAINS        = 3;

  localparam logic [7:0] LOSS_COUNT_MAX = 8'd255;

endpackage

// File: rtl/video_pll_lock_sync.sv
// ---------------------------------------------------------------------------
// video_pll_lock_sync
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the
// refclk domain.
// Ports:
//   refclk : reference clock
//   rst    : synchronous active-high reset, clears both flops
//   d      : asynchronous input
//   q      : synchronized output (two refclk edges of latency)
// ---------------------------------------------------------------------------
module video_pll_lock_sync (
  input  logic refclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge refclk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/video_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// video_pll_reset_sequencer
// Holds a video PLL in reset, waits for a stable lock, then releases the
// downstream reset domains one after another. Timed-out attempts are retried
// until the retry budget is spent, after which the block parks in FAULT.
// Ports:
//   refclk          : single clock (50 MHz)
//   rst             : synchronous active-high reset
//   locked          : PLL lock flag, asynchronous to refclk
//   pll_rst         : reset to the PLL
//   domain_rst      : per-domain active-high resets, [0] released first
//   ready           : all domains released and lock held
//   error           : retry budget exhausted
//   lock_lost_count : saturating count of lock-loss events
// Optional feature: define VIDEO_PLL_SEQ_LOSS_CNT_EN to implement the
// lock-loss counter; otherwise lock_lost_count is tied to zero.
// ---------------------------------------------------------------------------
module video_pll_reset_sequencer
  import video_pll_seq_pkg::*;
#(
  parameter int RESET_STRETCH      = DEF_RESET_STRETCH,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
  parameter int RELEASE_GAP        = DEF_RELEASE_GAP,
  parameter int NUM_DOMAINS        = DEF_NUM_DOMAINS
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   error,
  output logic [7:0]             lock_lost_count
);

  localparam int REL_LAST  = (NUM_DOMAINS - 1) * RELEASE_GAP;
  localparam int STRETCH_W = $clog2(RESET_STRETCH) + 1;
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int STABLE_W  = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int REL_W     = $clog2(REL_LAST + 1) + 1;
  localparam int RETRY_W   = $clog2(MAX_RETRIES) + 1;

  localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(RESET_STRETCH - 1);
  localparam logic [TO_W-1:0]      TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0]     REL_END      = REL_W'(REL_LAST);
  localparam logic [RETRY_W-1:0]   RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

  seq_state_t           state;
  seq_state_t           next_state;
  logic                 locked_s;
  logic                 timeout_hit;
  logic                 lock_loss;
  logic [STRETCH_W-1:0] stretch_cnt;
  logic [TO_W-1:0]      timeout_cnt;
  logic [STABLE_W-1:0]  stable_cnt;
  logic [REL_W-1:0]     release_cnt;
  logic [RETRY_W-1:0]   retry_cnt;

  video_pll_lock_sync u_lock_sync (
    .refclk (refclk),
    .rst    (rst),
    .d      (locked),
    .q      (locked_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) state <= ST_PLL_RST;
    else     state <= next_state;
  end

  // Timeout takes priority over lock progress so an attempt never exceeds
  // its cycle budget. The WAIT_LOCK cycle that sees lock counts as the first
  // stable cycle, hence the STABLE exit one count early.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    lock_loss   = 1'b0;
    case (state)
      ST_PLL_RST: begin
        if (stretch_cnt == STRETCH_LAST) next_state = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (timeout_cnt == TO_LAST) timeout_hit = 1'b1;
        else if (locked_s)          next_state  = ST_STABLE;
      end
      ST_STABLE: begin
        if (timeout_cnt == TO_LAST)         timeout_hit = 1'b1;
        else if (!locked_s)                 next_state  = ST_WAIT_LOCK;
        else if (stable_cnt >= STABLE_LAST) next_state  = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!locked_s) begin
          lock_loss  = 1'b1;
          next_state = ST_PLL_RST;
        end else if (release_cnt == REL_END) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          lock_loss  = 1'b1;
          next_state = ST_PLL_RST;
        end
      end
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_PLL_RST;
    endcase
    if (timeout_hit) begin
      next_state = (retry_cnt == RETRY_LAST) ? ST_FAULT : ST_PLL_RST;
    end
  end

  // Domain i drops out of reset i*RELEASE_GAP cycles into RELEASE.
  always_comb begin
    pll_rst    = (state == ST_PLL_RST) || (state == ST_FAULT);
    ready      = (state == ST_RUN);
    error      = (state == ST_FAULT);
    domain_rst = '1;
    if (state == ST_RUN) begin
      domain_rst = '0;
    end else if (state == ST_RELEASE) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        domain_rst[i] = (int'(release_cnt) < i * RELEASE_GAP);
      end
    end
  end

  // Each counter is cleared whenever its state is not continuing, so every
  // entry starts from zero and none can run past its limit. The timeout
  // counter spans WAIT_LOCK and STABLE together so lock flicker cannot
  // extend an attempt.
  always_ff @(posedge refclk) begin
    if (rst) begin
      stretch_cnt <= '0;
      timeout_cnt <= '0;
      stable_cnt  <= '0;
      release_cnt <= '0;
      retry_cnt   <= '0;
    end else begin
      stretch_cnt <= (state == ST_PLL_RST && next_state == ST_PLL_RST)
                     ? stretch_cnt + 1'b1 : '0;
      timeout_cnt <= ((state == ST_WAIT_LOCK || state == ST_STABLE) &&
                      (next_state == ST_WAIT_LOCK || next_state == ST_STABLE))
                     ? timeout_cnt + 1'b1 : '0;
      if (state == ST_WAIT_LOCK && next_state == ST_STABLE)
        stable_cnt <= STABLE_W'(1);
      else if (state == ST_STABLE && next_state == ST_STABLE)
        stable_cnt <= stable_cnt + 1'b1;
      else
        stable_cnt <= '0;
      release_cnt <= (state == ST_RELEASE && next_state == ST_RELEASE)
                     ? release_cnt + 1'b1 : '0;
      if (timeout_hit)
        retry_cnt <= retry_cnt + 1'b1;
      else if (next_state == ST_RUN && state == ST_RELEASE)
        retry_cnt <= '0;
    end
  end

`ifdef VIDEO_PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;

  // Saturates rather than wrapping so a flaky PLL never looks healthy.
  always_ff @(posedge refclk) begin
    if (rst)                                        loss_cnt <= '0;
    else if (lock_loss && loss_cnt != LOSS_COUNT_MAX) loss_cnt <= loss_cnt + 1'b1;
  end

  assign lock_lost_count = loss_cnt;
`else
  assign lock_lost_count = 8'd0;
`endif

endmodule

// File: tb/tb_video_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_video_pll_reset_sequencer
// Directed bench for video_pll_reset_sequencer with RESET_STRETCH=4,
// LOCK_STABLE_CYCLES=8, TIMEOUT_CYCLES=20, MAX_RETRIES=2, RELEASE_GAP=2,
// NUM_DOMAINS=3. Expected lock_lost_count follows VIDEO_PLL_SEQ_LOSS_CNT_EN.
// Cycle c means the interval just after the c-th edge following the last
// edge that sampled rst=1 (c=0 is the first PLL_RST cycle).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_pll_reset_sequencer;

`ifdef VIDEO_PLL_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       ready;
  logic       error;
  logic [7:0] lock_lost_count;

  int total = 0;
  int bad   = 0;

  video_pll_reset_sequencer #(
    .RESET_STRETCH      (4),
    .LOCK_STABLE_CYCLES (8),
    .TIMEOUT_CYCLES     (20),
    .MAX_RETRIES        (2),
    .RELEASE_GAP        (2),
    .NUM_DOMAINS        (3)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .locked          (locked),
    .pll_rst         (pll_rst),
    .domain_rst      (domain_rst),
    .ready           (ready),
    .error           (error),
    .lock_lost_count (lock_lost_count)
  );

  // 50 MHz reference clock.
  always #10 refclk = ~refclk;

  // Hard stop in case a loop ever stalls.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Leaves the bench at cycle 0 with the given raw lock level.
  task automatic do_reset(input logic lock_val);
    locked = lock_val;
    rst    = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    locked = 1'b0;
    rst    = 1'b1;
    repeat (3) tick();
    total++; if (pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_pll_rst got=%b exp=1", pll_rst); end
    total++; if (domain_rst !== 3'b111) begin bad++; $display("[TB] FAIL reset_domain_rst got=%b exp=111", domain_rst); end
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", ready); end
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error got=%b exp=0", error); end
    total++; if (lock_lost_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_loss_count got=%0d exp=0", lock_lost_count); end
  endtask

  task automatic test_basic_sequence();
    logic [2:0] exp_dom;
    do_reset(1'b1);
    for (int c = 0; c <= 19; c++) begin
      exp_dom = (c < 12) ? 3'b111 : (c < 14) ? 3'b110 : (c < 16) ? 3'b100 : 3'b000;
      total++; if (pll_rst !== (c < 4)) begin bad++; $display("[TB] FAIL basic_pll_rst c=%0d got=%b exp=%b", c, pll_rst, (c < 4)); end
      total++; if (domain_rst !== exp_dom) begin bad++; $display("[TB] FAIL basic_domain_rst c=%0d got=%b exp=%b", c, domain_rst, exp_dom); end
      total++; if (ready !== (c >= 17)) begin bad++; $display("[TB] FAIL basic_ready c=%0d got=%b exp=%b", c, ready, (c >= 17)); end
      tick();
    end
  endtask

  // Synchronized lock high for cycles 4..8, low 9..10, then steady from 11:
  // the stable count restarts, so RELEASE begins at cycle 19.
  task automatic test_stable_restart();
    logic [2:0] exp_dom;
    do_reset(1'b0);
    for (int c = 0; c <= 25; c++) begin
      exp_dom = (c < 19) ? 3'b111 : (c < 21) ? 3'b110 : (c < 23) ? 3'b100 : 3'b000;
      total++; if (domain_rst !== exp_dom) begin bad++; $display("[TB] FAIL restart_domain_rst c=%0d got=%b exp=%b", c, domain_rst, exp_dom); end
      total++; if (ready !== (c >= 24)) begin bad++; $display("[TB] FAIL restart_ready c=%0d got=%b exp=%b", c, ready, (c >= 24)); end
      locked = ((c >= 2) && (c <= 6)) || (c >= 9);
      tick();
    end
  endtask

  // Two attempts of 4 reset cycles + 20 wait cycles, then FAULT at cycle 48.
  task automatic test_timeout_fault();
    logic exp_pll;
    do_reset(1'b0);
    for (int c = 0; c <= 52; c++) begin
      exp_pll = (c < 4) || (c >= 24 && c < 28) || (c >= 48);
      total++; if (pll_rst !== exp_pll) begin bad++; $display("[TB] FAIL timeout_pll_rst c=%0d got=%b exp=%b", c, pll_rst, exp_pll); end
      total++; if (error !== (c >= 48)) begin bad++; $display("[TB] FAIL timeout_error c=%0d got=%b exp=%b", c, error, (c >= 48)); end
      total++; if (domain_rst !== 3'b111) begin bad++; $display("[TB] FAIL timeout_domain_rst c=%0d got=%b exp=111", c, domain_rst); end
      tick();
    end
    locked = 1'b1;
    repeat (20) tick();
    total++; if (error !== 1'b1) begin bad++; $display("[TB] FAIL fault_sticky_error got=%b exp=1", error); end
    total++; if (pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL fault_sticky_pll_rst got=%b exp=1", pll_rst); end
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL fault_sticky_ready got=%b exp=0", ready); end
    do_reset(1'b0);
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL fault_cleared_error got=%b exp=0", error); end
  endtask

  // One-cycle lock drop in RUN, repeated 300 times; each re-sequence takes
  // 17 cycles from the PLL_RST entry to ready.
  task automatic test_lock_loss();
    int cyc;
    logic [7:0] exp_cnt;
    do_reset(1'b1);
    repeat (17) tick();
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL loss_initial_ready got=%b exp=1", ready); end
    for (int n = 1; n <= 300; n++) begin
      locked = 1'b0;
      tick();
      locked = 1'b1;
      tick();
      total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL loss_sync_delay_ready n=%0d got=%b exp=1", n, ready); end
      tick();
      total++; if (domain_rst !== 3'b111 || ready !== 1'b0) begin
        bad++; $display("[TB] FAIL loss_drop n=%0d got=%b/%b exp=111/0", n, domain_rst, ready);
      end
      exp_cnt = LOSS_EN ? ((n > 255) ? 8'd255 : 8'(n)) : 8'd0;
      total++; if (lock_lost_count !== exp_cnt) begin bad++; $display("[TB] FAIL loss_count n=%0d got=%0d exp=%0d", n, lock_lost_count, exp_cnt); end
      cyc = 0;
      while (ready !== 1'b1 && cyc < 40) begin
        tick();
        cyc++;
      end
      total++; if (cyc != 17) begin bad++; $display("[TB] FAIL loss_resequence n=%0d got=%0d exp=17 cycles", n, cyc); end
    end
  endtask

  // rst during RELEASE (domain_rst=110) aborts at once; the next sequence
  // starts fully from scratch.
  task automatic test_reset_mid_release();
    logic [2:0] exp_dom;
    do_reset(1'b1);
    total++; if (lock_lost_count !== 8'd0) begin bad++; $display("[TB] FAIL midrel_count_cleared got=%0d exp=0", lock_lost_count); end
    repeat (12) tick();
    total++; if (domain_rst !== 3'b110) begin bad++; $display("[TB] FAIL midrel_before got=%b exp=110", domain_rst); end
    rst = 1'b1;
    tick();
    total++; if (domain_rst !== 3'b111) begin bad++; $display("[TB] FAIL midrel_abort_domain got=%b exp=111", domain_rst); end
    total++; if (pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL midrel_abort_pll_rst got=%b exp=1", pll_rst); end
    rst = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      exp_dom = (c < 12) ? 3'b111 : (c < 14) ? 3'b110 : (c < 16) ? 3'b100 : 3'b000;
      total++; if (domain_rst !== exp_dom) begin bad++; $display("[TB] FAIL midrel_redo_domain c=%0d got=%b exp=%b", c, domain_rst, exp_dom); end
      total++; if (ready !== (c >= 17)) begin bad++; $display("[TB] FAIL midrel_redo_ready c=%0d got=%b exp=%b", c, ready, (c >= 17)); end
      if (c < 17) tick();
    end
  endtask

  initial begin
    $display("[TB] start, loss counter enabled=%0d", LOSS_EN);
    test_reset();
    test_basic_sequence();
    test_stable_restart();
    test_timeout_fault();
    test_lock_loss();
    test_reset_mid_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
